// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage -- PC, imem req/ack, one-entry stall hold, IF/ID register.
// Ports: clk, rst (async high); imemReq/imemAddr/imemAck/imemRData; stall, branchTaken,
// branchTarget from decode; ifidValid/ifidInstr/ifidPC/ifidPCPlus4, opcode/funct to decode.
// Macro BRANCH_DELAY_SLOT_EN: defined = MIPS delay slot; undefined = branch squashes the slot.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRData,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        ifidValid,
    output logic [31:0] ifidInstr,
    output logic [31:0] ifidPC,
    output logic [31:0] ifidPCPlus4,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]  state, n_state;
    logic [31:0] pc, n_pc;
    logic [31:0] holdBuf, n_hold;
    logic        redirPend, n_rp;
    logic [31:0] redirAddr, n_ra;
    logic        n_valid;
    logic [31:0] n_instr, n_ipc;

    logic        take;
    logic        deliver;
    logic        bubble;
    logic [31:0] dword;
    logic [31:0] pc4;

    // Branches seen during a stall are ignored; decode re-asserts them.
    assign take = branchTaken && !stall;
    assign pc4  = pc + 32'd4;

    assign imemReq     = (state == S_FETCH);
    assign imemAddr    = pc;
    assign ifidPCPlus4 = ifidPC + 32'd4;
    assign opcode      = ifidInstr[31:26];
    assign funct       = ifidInstr[5:0];

    always_comb begin
        n_state = state;
        n_pc    = pc;
        n_hold  = holdBuf;
        n_rp    = redirPend;
        n_ra    = redirAddr;
        n_valid = ifidValid;
        n_instr = ifidInstr;
        n_ipc   = ifidPC;
        deliver = 1'b0;
        bubble  = 1'b0;
        dword   = holdBuf;

`ifdef BRANCH_DELAY_SLOT_EN
        unique case (state)
            S_BOOT: n_state = S_FETCH;
            S_FETCH: begin
                if (imemAck) begin
                    if (stall) begin
                        n_hold  = imemRData;
                        n_state = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        dword   = imemRData;
                    end
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    deliver = 1'b1;
                    n_state = S_FETCH;
                end
            end
            default: n_state = S_BOOT;
        endcase

        // The word being delivered is the slot; the fetch after it goes to
        // the freshest redirect (a same-cycle branch wins over a pending one).
        if (deliver) begin
            n_rp = 1'b0;
            if (take)
                n_pc = branchTarget;
            else if (redirPend)
                n_pc = redirAddr;
            else
                n_pc = pc4;
        end else if (take) begin
            n_rp = 1'b1;
            n_ra = branchTarget;
        end
`else
        unique case (state)
            S_BOOT: begin
                n_state = S_FETCH;
                if (take)
                    n_pc = branchTarget;
            end
            S_FETCH: begin
                if (imemAck) begin
                    // Data returned for a squashed address is dropped.
                    if (redirPend || take) begin
                        n_pc   = take ? branchTarget : redirAddr;
                        n_rp   = 1'b0;
                        bubble = !stall;
                    end else if (stall) begin
                        n_hold  = imemRData;
                        n_state = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        dword   = imemRData;
                    end
                end else begin
                    // Request must stay stable, so remember the target.
                    if (take) begin
                        n_rp = 1'b1;
                        n_ra = branchTarget;
                    end
                    bubble = !stall;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    n_state = S_FETCH;
                    if (take) begin
                        n_pc   = branchTarget;
                        bubble = 1'b1;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            default: n_state = S_BOOT;
        endcase

        if (deliver)
            n_pc = pc4;
`endif

        if (deliver) begin
            n_valid = 1'b1;
            n_instr = dword;
            n_ipc   = pc;
        end else if (bubble) begin
            n_valid = 1'b0;
            n_instr = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            holdBuf   <= 32'h0;
            redirPend <= 1'b0;
            redirAddr <= 32'h0;
            ifidValid <= 1'b0;
            ifidInstr <= 32'h0;
            ifidPC    <= 32'h0;
        end else begin
            state     <= n_state;
            pc        <= n_pc;
            holdBuf   <= n_hold;
            redirPend <= n_rp;
            redirAddr <= n_ra;
            ifidValid <= n_valid;
            ifidInstr <= n_instr;
            ifidPC    <= n_ipc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch.
// Memory returns word == address after a programmable number of wait cycles.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRData;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        ifidValid;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPC;
    logic [31:0] ifidPCPlus4;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    int total;
    int bad;
    int lat;
    int wcnt;

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemRData    (imemRData),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .ifidValid    (ifidValid),
        .ifidInstr    (ifidInstr),
        .ifidPC       (ifidPC),
        .ifidPCPlus4  (ifidPCPlus4),
        .opcode       (opcode),
        .funct        (funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imemAck   = imemReq && (wcnt >= lat);
    assign imemRData = imemAddr;

    always @(posedge clk) begin
        if (imemReq && !imemAck)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Returns at the negedge of the first cycle in S_FETCH.
    task automatic do_reset(input int l);
        rst          = 1'b1;
        stall        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 32'h0;
        lat          = l;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   imemReq,     32'd0);
        check({tag, "_addr"},  imemAddr,    32'h3000);
        check({tag, "_valid"}, ifidValid,   32'd0);
        check({tag, "_instr"}, ifidInstr,   32'h0);
        check({tag, "_pc"},    ifidPC,      32'h0);
        check({tag, "_pc4"},   ifidPCPlus4, 32'h4);
        check({tag, "_op"},    opcode,      32'h0);
        check({tag, "_fn"},    funct,       32'h0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        lat          = 0;
        rst          = 1'b0;
        stall        = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = 32'h0;

        // Reset values and zero-wait streaming
        #3 rst = 1'b1;
        #1 check_reset_vals("rst0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("boot_req", imemReq, 32'd0);
        tick();
        check("s1_req",  imemReq,  32'd1);
        check("s1_addr", imemAddr, 32'h3000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("s1_valid", ifidValid, 32'd1);
            check("s1_instr", ifidInstr, 32'h3000 + 32'(4 * k));
            check("s1_next",  imemAddr,  32'h3004 + 32'(4 * k));
        end
        check("s1_pc",  ifidPC,      32'h3008);
        check("s1_pc4", ifidPCPlus4, 32'h300C);
        check("s1_op",  opcode,      32'h0);
        check("s1_fn",  funct,       32'h08);

        // Two wait cycles per fetch: valid pattern 1,0,0
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                check("w2_addr", imemAddr, 32'h3000 + 32'(4 * k));
                if (j == 0 && k > 0) begin
                    check("w2_valid", ifidValid, 32'd1);
                    check("w2_instr", ifidInstr, 32'h3000 + 32'(4 * (k - 1)));
                end else begin
                    check("w2_valid", ifidValid, 32'd0);
                    check("w2_instr", ifidInstr, 32'h0);
                end
                tick();
            end
        end

        // Stall for 3 cycles over the ack at 3008
        do_reset(0);
        tick();
        tick();
        check("st_pre", ifidInstr, 32'h3004);
        check("st_ack", imemAck,   32'd1);
        stall = 1'b1;
        tick();
        check("st_req1", imemReq,   32'd0);
        check("st_hld1", ifidInstr, 32'h3004);
        tick();
        check("st_req2", imemReq,   32'd0);
        check("st_hld2", ifidInstr, 32'h3004);
        check("st_vld2", ifidValid, 32'd1);
        tick();
        stall = 1'b0;
        tick();
        check("st_rel",  ifidInstr, 32'h3008);
        check("st_rpc",  ifidPC,    32'h3008);
        check("st_nreq", imemReq,   32'd1);
        check("st_nadr", imemAddr,  32'h300C);
        tick();
        check("st_nxt",  ifidInstr, 32'h300C);

        // Branch to 3100 while IF/ID holds 3004 (same-cycle ack)
        do_reset(0);
        tick();
        tick();
        check("br_pre", ifidInstr, 32'h3004);
        branchTaken  = 1'b1;
        branchTarget = 32'h3100;
        tick();
        branchTaken = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        check("br_slot",  ifidInstr, 32'h3008);
        check("br_sval",  ifidValid, 32'd1);
`else
        check("br_bub",   ifidInstr, 32'h0);
        check("br_bval",  ifidValid, 32'd0);
`endif
        check("br_addr", imemAddr, 32'h3100);
        tick();
        check("br_tgt",  ifidInstr, 32'h3100);
        check("br_tval", ifidValid, 32'd1);
        check("br_next", imemAddr,  32'h3104);

        // Branch to 3200 while the request for 3004 is outstanding
        do_reset(1);
        tick();
        tick();
        check("bo_pre",  ifidInstr, 32'h3000);
        check("bo_ack",  imemAck,   32'd0);
        branchTaken  = 1'b1;
        branchTarget = 32'h3200;
        tick();
        branchTaken = 1'b0;
        check("bo_held", imemAddr,  32'h3004);
        check("bo_v1",   ifidValid, 32'd0);
        tick();
        check("bo_addr", imemAddr,  32'h3200);
`ifdef BRANCH_DELAY_SLOT_EN
        check("bo_slot", ifidInstr, 32'h3004);
`else
        check("bo_drop", ifidInstr, 32'h0);
`endif
        tick();
        tick();
        check("bo_tgt",  ifidInstr, 32'h3200);
        check("bo_tval", ifidValid, 32'd1);

        // Branch during stall is ignored
        do_reset(0);
        tick();
        tick();
        stall        = 1'b1;
        branchTaken  = 1'b1;
        branchTarget = 32'h3100;
        tick();
        tick();
        stall       = 1'b0;
        branchTaken = 1'b0;
        tick();
        check("bs_rel",  ifidInstr, 32'h3008);
        check("bs_addr", imemAddr,  32'h300C);
        tick();
        check("bs_nxt",  ifidInstr, 32'h300C);

        // Reset while a request waits for its ack
        do_reset(0);
        tick();
        tick();
        lat = 3;
        tick();
        check("rm_req",  imemReq,  32'd1);
        check("rm_addr", imemAddr, 32'h3008);
        check("rm_ack",  imemAck,  32'd0);
        #2 rst = 1'b1;
        #1 check_reset_vals("rm");
        lat = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rm_req2",  imemReq,   32'd1);
        check("rm_addr2", imemAddr,  32'h3000);
        tick();
        check("rm_first", ifidInstr, 32'h3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
